// File: rtl/mux_arb_nch.sv
// mux_arb_nch: N-channel registered multiplexer with valid/ready handshake.
// One requesting channel is chosen per cycle, either by a forced select or by
// the built-in arbiter, and captured into a one-entry output register.
// Build option: define MUX_RR_ARB_EN for round-robin arbitration; otherwise the
// arbiter is fixed priority (lowest index wins) and no pointer is built.
module mux_arb_nch #(
    parameter  int WIDTH = 4,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 force_en,
    input  logic [SELW-1:0]      force_sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             force_vld;
    logic             arb_vld;
    logic [SELW-1:0]  arb_idx;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    // Forced path: grant only if force_sel names an existing, valid channel.
    // Comparing against each index keeps out-of-range selects (>= NCH) inert.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        force_vld = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (force_sel == SELW'(i) && in_valid[i]) begin
                force_vld = 1'b1;
            end
        end
    end

`ifdef MUX_RR_ARB_EN
    logic [SELW-1:0] ptr;

    // Round-robin search: start at ptr, ascend, wrap at NCH; first valid wins.
    // Scanning offsets from high to low lets the smallest offset overwrite.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (in_valid[idx]) begin
                arb_vld = 1'b1;
                arb_idx = SELW'(idx);
            end
        end
    end

    // Pointer advances past the winner on arbitrated transfers only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer && !force_en) begin
            ptr <= (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    // Fixed priority: lowest valid index wins (scan high to low, last hit wins).
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                arb_vld = 1'b1;
                arb_idx = SELW'(i);
            end
        end
    end
`endif

    // Grant selection, handshake and data mux for the chosen channel.
    always_comb begin
        grant_vld = force_en ? force_vld : arb_vld;
        grant_idx = force_en ? force_sel : arb_idx;
        can_load  = !out_valid || out_ready;
        // rst_n gates the transfer so in_ready is held low during reset.
        xfer      = grant_vld && can_load && rst_n;
        in_ready  = '0;
        sel_data  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == SELW'(i)) begin
                in_ready[i] = xfer;
                sel_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: load on transfer, clear valid on drain, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
